// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Optional call/return stack is enabled with PC_SEQ_CALL_EN.
package pc_seq_pkg;

    localparam int D        = 10;
    localparam int N_TGT    = 16;
    localparam int TW       = $clog2(N_TGT);
    localparam int RS_DEPTH = 4;
    localparam int RW       = $clog2(RS_DEPTH);
    localparam int SPW      = $clog2(RS_DEPTH + 1);

    typedef logic [D-1:0]  pc_t;
    typedef logic [TW-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    localparam pc_t DEFAULT_TGT [N_TGT] = '{
        10'd0,  10'd11, 10'd80, 10'd68,
        10'd113, 10'd53, 10'd56, 10'd59,
        10'd79, 10'd20, 10'd95, 10'd0,
        10'd0,  10'd0,  10'd0,  10'd0
    };

    localparam logic [N_TGT-1:0] DEFAULT_VALID = 16'h07ff;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/config side bundle of the PC sequencer.
// call_en/ret_en exist only when PC_SEQ_CALL_EN is defined.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic start;
    logic stall;
    logic branch_en;
    logic branch_taken;
    idx_t tgt_idx;
    logic halt_req;
    logic cfg_we;
    idx_t cfg_idx;
    pc_t  cfg_data;
`ifdef PC_SEQ_CALL_EN
    logic call_en;
    logic ret_en;
`endif
    pc_t  pc;
    logic running;
    logic done;
    logic err;

    modport master (
        output start, stall, branch_en, branch_taken,
        output tgt_idx, halt_req,
        output cfg_we, cfg_idx, cfg_data,
`ifdef PC_SEQ_CALL_EN
        output call_en, ret_en,
`endif
        input  pc, running, done, err
    );

    modport slave (
        input  start, stall, branch_en, branch_taken,
        input  tgt_idx, halt_req,
        input  cfg_we, cfg_idx, cfg_data,
`ifdef PC_SEQ_CALL_EN
        input  call_en, ret_en,
`endif
        output pc, running, done, err
    );

endinterface

// File: rtl/pc_target_table.sv
// Writable branch-target table with valid bits.
// Async read, sync write, async reset to package defaults.
module pc_target_table
    import pc_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic we,
    input  idx_t wr_idx,
    input  pc_t  wr_data,
    input  idx_t rd_idx,
    output pc_t  rd_data,
    output logic rd_valid,
    output pc_t  entry0
);

    pc_t              tgt [N_TGT];
    logic [N_TGT-1:0] valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt   <= DEFAULT_TGT;
            valid <= DEFAULT_VALID;
        end else if (we) begin
            tgt[wr_idx]   <= wr_data;
            valid[wr_idx] <= 1'b1;
        end
    end

    assign rd_data  = tgt[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign entry0   = tgt[0];

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: run/halt FSM, PC register, target table.
// PC_SEQ_CALL_EN adds a call/return stack.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    state_t state, state_n;
    pc_t    pc_r, pc_n;
    logic   err_r, err_n;
    pc_t    tgt, entry0;
    logic   tgt_valid;
    pc_t    pc_inc;
    logic   taken;

    assign pc_inc = pc_r + 1'b1;
    assign taken  = bus.branch_en && bus.branch_taken;

    // table only accepts writes outside RUN
    pc_target_table u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (bus.cfg_we && state != RUN),
        .wr_idx   (bus.cfg_idx),
        .wr_data  (bus.cfg_data),
        .rd_idx   (bus.tgt_idx),
        .rd_data  (tgt),
        .rd_valid (tgt_valid),
        .entry0   (entry0)
    );

`ifdef PC_SEQ_CALL_EN
    pc_t            rs [RS_DEPTH];
    logic [SPW-1:0] sp, sp_n;
    logic           push;
    logic [RW-1:0]  top;

    assign top = RW'(sp - 1'b1);
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc_r;
        err_n   = err_r;
`ifdef PC_SEQ_CALL_EN
        sp_n    = sp;
        push    = 1'b0;
`endif
        case (state)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_n = RUN;
                    pc_n    = entry0;
                    err_n   = 1'b0;
`ifdef PC_SEQ_CALL_EN
                    sp_n    = '0;
`endif
                end
            end
            RUN: begin
                if (bus.cfg_we) err_n = 1'b1;
                if (bus.stall) begin
                    pc_n = pc_r;
                end else if (bus.halt_req) begin
                    state_n = HALT;
                end
`ifdef PC_SEQ_CALL_EN
                else if (bus.call_en) begin
                    if (!tgt_valid || sp == SPW'(RS_DEPTH)) begin
                        err_n   = 1'b1;
                        state_n = HALT;
                    end else begin
                        push = 1'b1;
                        sp_n = sp + 1'b1;
                        pc_n = tgt;
                    end
                end
`endif
                else if (taken) begin
                    if (!tgt_valid) begin
                        err_n   = 1'b1;
                        state_n = HALT;
                    end else begin
                        pc_n = tgt;
                    end
                end
`ifdef PC_SEQ_CALL_EN
                else if (bus.ret_en) begin
                    if (sp == '0) begin
                        err_n   = 1'b1;
                        state_n = HALT;
                    end else begin
                        sp_n = sp - 1'b1;
                        pc_n = rs[top];
                    end
                end
`endif
                else if (&pc_r) begin
                    pc_n    = '0;
                    err_n   = 1'b1;
                    state_n = HALT;
                end else begin
                    pc_n = pc_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc_r  <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_n;
            pc_r  <= pc_n;
            err_r <= err_n;
        end
    end

`ifdef PC_SEQ_CALL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            rs <= '{default: '0};
        end else begin
            sp <= sp_n;
            if (push) rs[sp[RW-1:0]] <= pc_inc;
        end
    end
`endif

    assign bus.pc      = pc_r;
    assign bus.running = (state == RUN);
    assign bus.done    = (state == HALT);
    assign bus.err     = err_r;

endmodule
